// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel load,
// count enable and wrap-or-saturate behaviour at the limits; tc chains wider counters.
module counter_updown_mod #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic at_top;
    logic at_bot;

    // >= so that a forced out-of-range value behaves like MAX_VAL on an up step
    assign at_top = (count >= MAXV);
    assign at_bot = (count == '0);
    assign tc     = en & (up ? (count == MAXV) : at_bot);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RSTV;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (load) begin
            count <= (load_val > MAXV) ? MAXV : load_val;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            sat  <= 1'b0;
            if (up) begin
                if (at_top) begin
                    if (SATURATE) begin
                        sat <= 1'b1;
                    end else begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    if (SATURATE) begin
                        sat <= 1'b1;
                    end else begin
                        count <= MAXV;
                        wrap  <= 1'b1;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end else begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: four parameterisations plus a two-stage 4-bit cascade, driven by
// directed scenarios and random stimulus compared against an arithmetic reference model.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] lv;

    logic [7:0] cnt [4];
    logic       tcv [4];
    logic       wrv [4];
    logic       stv [4];

    logic [3:0] cas_lo, cas_hi;
    logic       cas_lo_tc, cas_hi_tc, cas_lo_wr, cas_hi_wr, cas_lo_st, cas_hi_st;

    int checks   = 0;
    int failures = 0;

    int m_cnt [4];
    bit m_w   [4];
    bit m_s   [4];
    int m_cas;
    int maxv  [4] = '{255, 9, 9, 150};
    bit satm  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    counter_updown_mod dut0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
        .count(cnt[0]), .tc(tcv[0]), .wrap(wrv[0]), .sat(stv[0]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(9)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
        .count(cnt[1]), .tc(tcv[1]), .wrap(wrv[1]), .sat(stv[1]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
        .count(cnt[2]), .tc(tcv[2]), .wrap(wrv[2]), .sat(stv[2]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(150)) dut3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
        .count(cnt[3]), .tc(tcv[3]), .wrap(wrv[3]), .sat(stv[3]));

    counter_updown_mod #(.WIDTH(4)) cas_low (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .count(cas_lo), .tc(cas_lo_tc), .wrap(cas_lo_wr), .sat(cas_lo_st));
    counter_updown_mod #(.WIDTH(4)) cas_high (
        .clk(clk), .reset(reset), .en(cas_lo_tc), .up(up), .load(load), .load_val(lv[3:0]),
        .count(cas_hi), .tc(cas_hi_tc), .wrap(cas_hi_wr), .sat(cas_hi_st));

    task automatic set_in(input logic r, input logic l, input logic e, input logic u,
                          input logic [7:0] v);
        reset = r; load = l; en = e; up = u; lv = v;
    endtask

    // Advance one edge; the reference model follows the counting rules arithmetically.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_w[i] = 1'b0; m_s[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (int'(lv) > maxv[i]) ? maxv[i] : int'(lv);
                m_w[i] = 1'b0; m_s[i] = 1'b0;
            end else if (en) begin
                m_w[i] = 1'b0; m_s[i] = 1'b0;
                if (up && m_cnt[i] >= maxv[i]) begin
                    if (satm[i]) m_s[i] = 1'b1;
                    else begin m_cnt[i] = 0; m_w[i] = 1'b1; end
                end else if (!up && m_cnt[i] == 0) begin
                    if (satm[i]) m_s[i] = 1'b1;
                    else begin m_cnt[i] = maxv[i]; m_w[i] = 1'b1; end
                end else begin
                    m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                end
            end else begin
                m_w[i] = 1'b0; m_s[i] = 1'b0;
            end
        end
        if (reset)     m_cas = 0;
        else if (load) m_cas = int'(lv[3:0]) * 17;
        else if (en)   m_cas = up ? (m_cas + 1) % 256 : (m_cas + 255) % 256;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] !== 8'd0 || wrv[i] !== 1'b0 || stv[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d]: count=%0d wrap=%b sat=%b expected 0/0/0", i, cnt[i], wrv[i], stv[i]);
            end
        end
        checks++;
        if ({cas_hi, cas_lo} !== 8'h00) begin
            failures++;
            $display("FAIL reset_cascade: got %h expected 00", {cas_hi, cas_lo});
        end
    endtask

    task automatic test_full_wrap();
        int nwrap = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        for (int i = 0; i < 256; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
            #1;
            checks++;
            if (tcv[0] !== (i == 255)) begin
                failures++;
                $display("FAIL full_tc at %0d: got %b expected %b", i, tcv[0], (i == 255));
            end
            step();
            if (wrv[0] === 1'b1) nwrap++;
            checks++;
            if (cnt[0] !== 8'((i + 1) % 256) || wrv[0] !== (i == 255)) begin
                failures++;
                $display("FAIL full_count step %0d: count=%0d wrap=%b expected %0d/%b",
                         i, cnt[0], wrv[0], (i + 1) % 256, (i == 255));
            end
        end
        checks++;
        if (nwrap != 1) begin
            failures++;
            $display("FAIL full_wrap_once: got %0d wrap pulses expected 1", nwrap);
        end
    endtask

    task automatic test_down_wrap();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step();
        checks++;
        if (cnt[1] !== 8'd9 || wrv[1] !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap: count=%0d wrap=%b expected 9/1", cnt[1], wrv[1]);
        end
        step();
        checks++;
        if (cnt[1] !== 8'd8 || wrv[1] !== 1'b0) begin
            failures++;
            $display("FAIL down_after_wrap: count=%0d wrap=%b expected 8/0", cnt[1], wrv[1]);
        end
    endtask

    task automatic test_saturate();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
        step();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
            step();
            checks++;
            if (cnt[2] !== 8'd9 || stv[2] !== (k > 0) || wrv[2] !== 1'b0) begin
                failures++;
                $display("FAIL sat_hold %0d: count=%0d sat=%b wrap=%b expected 9/%b/0",
                         k, cnt[2], stv[2], wrv[2], (k > 0));
            end
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step();
        checks++;
        if (cnt[2] !== 8'd8 || stv[2] !== 1'b0) begin
            failures++;
            $display("FAIL sat_release: count=%0d sat=%b expected 8/0", cnt[2], stv[2]);
        end
    endtask

    task automatic test_load();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 8'd200);
        step();
        checks++;
        if (cnt[3] !== 8'd150 || wrv[3] !== 1'b0 || cnt[0] !== 8'd200 || cnt[1] !== 8'd9) begin
            failures++;
            $display("FAIL load_clamp: counts=%0d/%0d/%0d wrap=%b expected 150/200/9 wrap 0",
                     cnt[3], cnt[0], cnt[1], wrv[3]);
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'd42);
        step();
        checks++;
        if (cnt[3] !== 8'd0) begin
            failures++;
            $display("FAIL reset_over_load: count=%0d expected 0", cnt[3]);
        end
    endtask

    task automatic test_cascade();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        repeat (15) step();
        checks++;
        if ({cas_hi, cas_lo} !== 8'h0F) begin
            failures++;
            $display("FAIL cascade_0f: got %h expected 0f", {cas_hi, cas_lo});
        end
        step();
        checks++;
        if ({cas_hi, cas_lo} !== 8'h10) begin
            failures++;
            $display("FAIL cascade_carry: got %h expected 10", {cas_hi, cas_lo});
        end
        repeat (239) step();
        checks++;
        if ({cas_hi, cas_lo} !== 8'hFF) begin
            failures++;
            $display("FAIL cascade_ff: got %h expected ff", {cas_hi, cas_lo});
        end
    endtask

    task automatic test_random();
        int lo;
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tcv[i] !== (en && (up ? m_cnt[i] == maxv[i] : m_cnt[i] == 0))) begin
                    failures++;
                    $display("FAIL rand_tc[%0d] iter %0d: got %b count=%0d en=%b up=%b",
                             i, n, tcv[i], m_cnt[i], en, up);
                end
            end
            lo = m_cas % 16;
            checks++;
            if (cas_lo_tc !== (en && (up ? lo == 15 : lo == 0))) begin
                failures++;
                $display("FAIL rand_cascade_tc iter %0d: got %b low=%0d", n, cas_lo_tc, lo);
            end
            step();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cnt[i] !== 8'(m_cnt[i]) || wrv[i] !== m_w[i] || stv[i] !== m_s[i]) begin
                    failures++;
                    $display("FAIL rand_state[%0d] iter %0d: count=%0d wrap=%b sat=%b expected %0d/%b/%b",
                             i, n, cnt[i], wrv[i], stv[i], m_cnt[i], m_w[i], m_s[i]);
                end
            end
            checks++;
            if ({cas_hi, cas_lo} !== 8'(m_cas)) begin
                failures++;
                $display("FAIL rand_cascade iter %0d: got %h expected %h", n, {cas_hi, cas_lo}, 8'(m_cas));
            end
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_w[i] = 1'b0; m_s[i] = 1'b0;
        end
        m_cas = 0;
        @(negedge clk);
        test_reset();
        test_full_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_cascade();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
